dest_reg_tracker: RTL and testbench
===================================

// Module: dest_reg_tracker
// PURPOSE
//  Parametrised successor to the 2:1 RegDst mux in the execute stage. Selects the
//  write-register number (rt, rd or link register) and carries it with its write
//  enable through a DEPTH-stage shift pipeline (EX/MEM, MEM/WB, ...). From the
//  registered stages it produces per-stage source-match flags for the forwarding
//  and hazard units. Sits in the execute stage, fed by ID/EX and driven by the
//  pipeline stall/flush controls.
// PARAMETERS
//  AW        5   register-number width
//  DEPTH     3   tracked stages after EX (>=1); stage 0 = EX/MEM
//  LINK_REG  31  register number written by link (JAL-type) instructions
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         synchronous, active-high
//  stall          in   1         hold all stages
//  flush          in   1         insert bubble into stage 0
//  in_valid       in   1         EX holds a real instruction
//  reg_write_in   in   1         instruction writes the register file
//  reg_dst        in   2         00=rt, 01=rd, 10=LINK_REG, 11=illegal
//  rt_in          in   AW        instr[20:16]
//  rd_in          in   AW        instr[15:11]
//  src_a          in   AW        rs of the instruction in ID/EX
//  src_b          in   AW        rt of the instruction in ID/EX
//  cur_dest       out  AW        combinational selected destination
//  dest_out       out  DEPTH*AW  stage i in bits [i*AW +: AW]
//  dest_we_out    out  DEPTH     per-stage registered write enable
//  match_a        out  DEPTH     stage i will write src_a
//  match_b        out  DEPTH     stage i will write src_b
//  err_illegal    out  1         sticky: reg_dst==11 was accepted
// BEHAVIOUR
//  - cur_dest = rt_in / rd_in / LINK_REG for reg_dst 00/01/10; for 11 -> 0.
//  - we_next = in_valid & reg_write_in & (reg_dst!=11) & (cur_dest!=0).
//    Writes to register 0 are never tracked.
//  - Priority at each posedge: reset > flush/stall > shift.
//  - reset: all dest=0, all we=0, err_illegal=0. Outputs are valid the cycle after.
//  - Normal (!stall,!flush): stage0 <= {cur_dest,we_next}; stage i <= stage i-1.
//    Latency 1 cycle into stage 0; DEPTH cycles to leave the pipe.
//  - stall only: every stage holds; the inputs are ignored.
//  - flush only: stage0 <= {0,0}; stages 1..DEPTH-1 shift normally.
//  - flush & stall: stage0 <= {0,0}; stages 1..DEPTH-1 hold.
//  - match_a[i] = dest_we_out[i] & (dest[i]==src_a) & (src_a!=0); match_b same
//    with src_b. Purely combinational from the registered state and the src
//    inputs. Multiple bits may be set at once; the consumer prioritises the
//    lowest i.
//  - err_illegal sets on any posedge with in_valid & reg_dst==11 & !stall &
//    !flush. Cleared only by reset.
//  - Entries in the last stage drop off on shift. No wrap-around.
//  - dest_out for a stage with we=0 carries the selected value (or 0 after
//    reset/flush) and is don't-care to consumers.
// TESTING
//  1 reset: after reset, dest_out=0, dest_we_out=0, match_*=0, err_illegal=0.
//  2 select: reg_dst=00/01/10 with rt=5, rd=9, valid, write -> stage0 = 5/9/31
//    over 3 cycles. The entry then walks to stage DEPTH-1 and drops out.
//  3 r0 filter: rd=0, reg_dst=01, write -> dest_we_out[0]=0; src_a=0 -> match_a=0.
//  4 forwarding: rd=7 issued, then src_a=7, src_b=7 ->
//    match_a=match_b=001 then 010 then 100.
//  5 stall/flush: issue rd=3, then stall 2 cycles -> stage0 holds 3.
//    Then flush&stall -> stage0 bubble, stage1 unchanged.
//    Then flush -> stage1 becomes bubble.
//  6 illegal: reg_dst=11 while valid -> cur_dest=0, no we, err_illegal=1 next
//    cycle. Stays 1 until reset.

Source files
------------

// File: rtl/dest_reg_tracker.sv
// Execute-stage destination-register selector plus a DEPTH-stage shift pipeline
// of {dest, we} entries. It drives per-stage source-match flags for forwarding and hazard logic.
module dest_reg_tracker #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LINK_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                reg_write_in,
  input  logic [1:0]          reg_dst,
  input  logic [AW-1:0]       rt_in,
  input  logic [AW-1:0]       rd_in,
  input  logic [AW-1:0]       src_a,
  input  logic [AW-1:0]       src_b,
  output logic [AW-1:0]       cur_dest,
  output logic [DEPTH*AW-1:0] dest_out,
  output logic [DEPTH-1:0]    dest_we_out,
  output logic [DEPTH-1:0]    match_a,
  output logic [DEPTH-1:0]    match_b,
  output logic                err_illegal
);

  localparam logic [AW-1:0] LINK = AW'(LINK_REG);

  // in_valid qualifies the EX instruction. No ready exists: stall is the only
  // backpressure, and an instruction counts as accepted on an edge with !stall & !flush.
  logic [AW-1:0]    dest_q [DEPTH];
  logic [DEPTH-1:0] we_q;
  logic             err_q;
  logic             we_next;
  logic             illegal_sel;
  logic             accept;

  assign illegal_sel = (reg_dst == 2'b11);
  assign accept      = in_valid & ~stall & ~flush;

  always_comb begin
    cur_dest = '0;
    case (reg_dst)
      2'b00:   cur_dest = rt_in;
      2'b01:   cur_dest = rd_in;
      2'b10:   cur_dest = LINK;
      default: cur_dest = '0;
    endcase
  end

  // Register 0 is hard-wired. A write to it can never create a hazard.
  assign we_next = in_valid & reg_write_in & ~illegal_sel & (cur_dest != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) dest_q[i] <= '0;
      we_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (flush) begin
        dest_q[0] <= '0;
        we_q[0]   <= 1'b0;
      end else if (!stall) begin
        dest_q[0] <= cur_dest;
        we_q[0]   <= we_next;
      end
      // Older stages move only when not stalled. Flush affects only stage 0.
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (!stall) begin
          dest_q[i] <= dest_q[i-1];
          we_q[i]   <= we_q[i-1];
        end
      end
      if (accept && illegal_sel) err_q <= 1'b1;
    end
  end

  always_comb begin
    dest_out = '0;
    match_a  = '0;
    match_b  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dest_out[i*AW +: AW] = dest_q[i];
      match_a[i] = we_q[i] & (dest_q[i] == src_a) & (src_a != '0);
      match_b[i] = we_q[i] & (dest_q[i] == src_b) & (src_b != '0);
    end
  end

  assign dest_we_out = we_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Bench for dest_reg_tracker: a directed vector table, reset-priority checks and a
// randomized phase checked against a small behavioural model through an expected queue.
module tb_dest_reg_tracker;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int OW    = DEPTH*AW + 3*DEPTH + 1;

  logic                clk = 1'b0;
  logic                reset, stall, flush, in_valid, reg_write_in;
  logic [1:0]          reg_dst;
  logic [AW-1:0]       rt_in, rd_in, src_a, src_b, cur_dest;
  logic [DEPTH*AW-1:0] dest_out;
  logic [DEPTH-1:0]    dest_we_out, match_a, match_b;
  logic                err_illegal;

  dest_reg_tracker #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .reg_write_in(reg_write_in), .reg_dst(reg_dst),
    .rt_in(rt_in), .rd_in(rd_in), .src_a(src_a), .src_b(src_b),
    .cur_dest(cur_dest), .dest_out(dest_out), .dest_we_out(dest_we_out),
    .match_a(match_a), .match_b(match_b), .err_illegal(err_illegal)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       s, f, v, rw;
    logic [1:0] dst;
    logic [4:0] rt, rd, sa, sb, cur, d0, d1, d2;
    logic [2:0] we, ma, mb;
    logic       err;
  } vec_t;

  vec_t            vecs[20];
  logic [OW-1:0]   exp_q[$];
  int              checks = 0;
  int              errors = 0;

  // Reference model state for the random phase
  logic [AW-1:0]   m_d[DEPTH];
  logic [DEPTH-1:0] m_w;
  logic            m_err;

  function automatic vec_t mk(input logic s, f, v, rw, input logic [1:0] dst,
                              input logic [4:0] rt, rd, sa, sb, cur, d0, d1, d2,
                              input logic [2:0] we, ma, mb, input logic err);
    vec_t x;
    x.s = s; x.f = f; x.v = v; x.rw = rw; x.dst = dst;
    x.rt = rt; x.rd = rd; x.sa = sa; x.sb = sb; x.cur = cur;
    x.d0 = d0; x.d1 = d1; x.d2 = d2; x.we = we; x.ma = ma; x.mb = mb; x.err = err;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expected output record and compare every field
  task automatic compare(input string tag);
    logic [OW-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard queue empty", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, " dest_out"},    32'(dest_out),    32'(e[24:10]));
    chk({tag, " dest_we_out"}, 32'(dest_we_out), 32'(e[9:7]));
    chk({tag, " match_a"},     32'(match_a),     32'(e[6:4]));
    chk({tag, " match_b"},     32'(match_b),     32'(e[3:1]));
    chk({tag, " err_illegal"}, 32'(err_illegal), 32'(e[0]));
  endtask

  task automatic drive(input logic s, f, v, rw, input logic [1:0] dst,
                       input logic [4:0] rt, rd, sa, sb);
    stall = s; flush = f; in_valid = v; reg_write_in = rw; reg_dst = dst;
    rt_in = rt; rd_in = rd; src_a = sa; src_b = sb;
  endtask

  // Reset with the pipe busy (and optionally stalled): reset must win.
  task automatic do_reset(input logic st, input string tag);
    @(negedge clk);
    reset = 1'b1;
    drive(st, 1'b0, 1'b1, 1'b1, 2'b01, 5'd3, 5'd9, 5'd9, 5'd9);
    exp_q.push_back('0);
    @(posedge clk);
    #1 compare(tag);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0);

    //            s f v rw dst rt  rd  sa  sb  cur d0  d1  d2  we      ma      mb      err
    vecs[0]  = mk(0,0,1,1, 0,  5,  9,  0,  0,  5,  5,  0,  0,  3'b001, 3'b000, 3'b000, 0);
    vecs[1]  = mk(0,0,1,1, 1,  5,  9,  0,  0,  9,  9,  5,  0,  3'b011, 3'b000, 3'b000, 0);
    vecs[2]  = mk(0,0,1,1, 2,  5,  9,  5,  9,  31, 31, 9,  5,  3'b111, 3'b100, 3'b010, 0);
    vecs[3]  = mk(0,0,0,1, 0,  5,  9,  31, 5,  5,  5,  31, 9,  3'b110, 3'b010, 3'b000, 0);
    vecs[4]  = mk(0,0,0,0, 0,  5,  9,  31, 31, 5,  5,  5,  31, 3'b100, 3'b100, 3'b100, 0);
    vecs[5]  = mk(0,0,0,0, 0,  5,  9,  5,  5,  5,  5,  5,  5,  3'b000, 3'b000, 3'b000, 0);
    vecs[6]  = mk(0,0,1,1, 1,  5,  0,  0,  0,  0,  0,  5,  5,  3'b000, 3'b000, 3'b000, 0);
    vecs[7]  = mk(0,0,1,0, 1,  5,  12, 12, 0,  12, 12, 0,  5,  3'b000, 3'b000, 3'b000, 0);
    vecs[8]  = mk(0,0,1,1, 1,  0,  7,  7,  7,  7,  7,  12, 0,  3'b001, 3'b001, 3'b001, 0);
    vecs[9]  = mk(0,0,0,0, 0,  0,  0,  7,  7,  0,  0,  7,  12, 3'b010, 3'b010, 3'b010, 0);
    vecs[10] = mk(0,0,0,0, 0,  0,  0,  7,  7,  0,  0,  0,  7,  3'b100, 3'b100, 3'b100, 0);
    vecs[11] = mk(0,0,1,1, 1,  0,  4,  4,  7,  4,  4,  0,  0,  3'b001, 3'b001, 3'b000, 0);
    vecs[12] = mk(0,0,1,1, 1,  0,  3,  3,  4,  3,  3,  4,  0,  3'b011, 3'b001, 3'b010, 0);
    vecs[13] = mk(1,0,1,1, 1,  0,  20, 3,  4,  20, 3,  4,  0,  3'b011, 3'b001, 3'b010, 0);
    vecs[14] = mk(1,0,1,1, 3,  0,  20, 3,  4,  0,  3,  4,  0,  3'b011, 3'b001, 3'b010, 0);
    vecs[15] = mk(1,1,1,1, 1,  0,  20, 3,  4,  20, 0,  4,  0,  3'b010, 3'b000, 3'b010, 0);
    vecs[16] = mk(0,1,1,1, 3,  0,  20, 3,  4,  0,  0,  0,  4,  3'b100, 3'b000, 3'b100, 0);
    vecs[17] = mk(0,0,1,1, 3,  5,  9,  0,  0,  0,  0,  0,  0,  3'b000, 3'b000, 3'b000, 1);
    vecs[18] = mk(0,0,1,1, 0,  6,  9,  6,  0,  6,  6,  0,  0,  3'b001, 3'b001, 3'b000, 1);
    vecs[19] = mk(0,0,0,0, 0,  0,  0,  6,  6,  0,  0,  6,  0,  3'b010, 3'b010, 3'b010, 1);

    do_reset(1'b0, "reset");

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].s, vecs[i].f, vecs[i].v, vecs[i].rw, vecs[i].dst,
            vecs[i].rt, vecs[i].rd, vecs[i].sa, vecs[i].sb);
      exp_q.push_back({vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].we,
                       vecs[i].ma, vecs[i].mb, vecs[i].err});
      #1 chk($sformatf("vec%0d cur_dest", i), 32'(cur_dest), 32'(vecs[i].cur));
      @(posedge clk);
      #1 compare($sformatf("vec%0d", i));
    end

    // err_illegal is sticky and only reset clears it, even while stalled
    do_reset(1'b1, "reset_during_stall");

    // Randomized phase against a behavioural model
    for (int i = 0; i < DEPTH; i++) m_d[i] = '0;
    m_w   = '0;
    m_err = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0]    sel;
      logic             wn;
      logic [DEPTH-1:0] ma, mb;
      logic [DEPTH*AW-1:0] dpk;
      @(negedge clk);
      drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      case (reg_dst)
        2'b00:   sel = rt_in;
        2'b01:   sel = rd_in;
        2'b10:   sel = 5'd31;
        default: sel = 5'd0;
      endcase
      wn = in_valid && reg_write_in && reg_dst != 2'b11 && sel != 0;
      if (!stall) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          m_d[k] = m_d[k-1];
          m_w[k] = m_w[k-1];
        end
      end
      if (flush) begin
        m_d[0] = '0;
        m_w[0] = 1'b0;
      end else if (!stall) begin
        m_d[0] = sel;
        m_w[0] = wn;
      end
      if (in_valid && reg_dst == 2'b11 && !stall && !flush) m_err = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
        ma[k] = m_w[k] && m_d[k] == src_a && src_a != 0;
        mb[k] = m_w[k] && m_d[k] == src_b && src_b != 0;
        dpk[k*AW +: AW] = m_d[k];
      end
      exp_q.push_back({dpk, m_w, ma, mb, m_err});
      #1 chk($sformatf("rnd%0d cur_dest", n), 32'(cur_dest), 32'(sel));
      @(posedge clk);
      #1 compare($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
